// File: rtl/boot_loader_if.sv
// Upstream word stream plus instruction/data BRAM write ports and core handoff
// signals of the boot loader.
interface boot_loader_if;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic [9:0]  i_w_addr;
   logic [31:0] i_w_dat;
   logic        i_w_enb;
   logic [9:0]  d_w_addr;
   logic [31:0] d_w_dat;
   logic        d_w_enb;
   logic        d_bram_init_done;
   logic        pc_stall;
   logic        i_r_enb;
   logic        load_err;

   // Upstream source / system side.
   modport master (
      output s_valid, s_data,
      input  s_ready, i_w_addr, i_w_dat, i_w_enb, d_w_addr, d_w_dat, d_w_enb,
      input  d_bram_init_done, pc_stall, i_r_enb, load_err
   );

   // Loader side.
   modport slave (
      input  s_valid, s_data,
      output s_ready, i_w_addr, i_w_dat, i_w_enb, d_w_addr, d_w_dat, d_w_enb,
      output d_bram_init_done, pc_stall, i_r_enb, load_err
   );
endinterface

// File: rtl/boot_loader.sv
// Streams a tagged header, ND data words and NI instruction words into the BRAMs,
// then releases the core. Optional trailing XOR checksum: BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
   parameter logic [15:0] MAGIC = 16'hB007
) (
   input  logic         clk,
   input  logic         rst,
   boot_loader_if.slave bus
);

   typedef enum logic [2:0] {
      HDR    = 3'd0,
      LOAD_D = 3'd1,
      LOAD_I = 3'd2,
      CHK    = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_t;

`ifdef BOOT_LOADER_CHECKSUM_EN
   localparam state_t PAYLOAD_END = CHK;
`else
   localparam state_t PAYLOAD_END = DONE;
`endif

   function automatic logic [31:0] csum_step(input logic [31:0] acc, input logic [31:0] word);
      csum_step = acc ^ word;
   endfunction

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  nd_q;
   logic [7:0]  ni_q;
   logic [7:0]  cnt_q;
   logic        s_ready_q;
   logic [9:0]  i_w_addr_q;
   logic [31:0] i_w_dat_q;
   logic        i_w_enb_q;
   logic [9:0]  d_w_addr_q;
   logic [31:0] d_w_dat_q;
   logic        d_w_enb_q;
   logic        init_done_q;
   logic        pc_stall_q;
   logic        i_r_enb_q;
   logic        load_err_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [31:0] csum_q;
`endif
   logic        beat_s;

   // s_ready is a register, so the beat qualifier never loops back through s_valid.
   assign beat_s = bus.s_valid & s_ready_q;

   // Next-state decision; only an accepted beat moves the FSM.
   always_comb begin
      state_d = state_q;
      if (beat_s) begin
         case (state_q)
            HDR: begin
               if (bus.s_data[31:16] != MAGIC) begin
                  state_d = ERR;
               end else if (bus.s_data[7:0] != 8'd0) begin
                  state_d = LOAD_D;
               end else if (bus.s_data[15:8] != 8'd0) begin
                  state_d = LOAD_I;
               end else begin
                  state_d = PAYLOAD_END;
               end
            end
            LOAD_D: begin
               if (cnt_q == nd_q - 8'd1) begin
                  state_d = (ni_q != 8'd0) ? LOAD_I : PAYLOAD_END;
               end else begin
                  state_d = LOAD_D;
               end
            end
            LOAD_I: begin
               if (cnt_q == ni_q - 8'd1) begin
                  state_d = PAYLOAD_END;
               end else begin
                  state_d = LOAD_I;
               end
            end
            CHK: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
               state_d = (bus.s_data == csum_q) ? DONE : ERR;
`else
               state_d = ERR;
`endif
            end
            default: state_d = state_q;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State, counters and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HDR;
         nd_q        <= 8'd0;
         ni_q        <= 8'd0;
         cnt_q       <= 8'd0;
         s_ready_q   <= 1'b0;
         i_w_addr_q  <= 10'd0;
         i_w_dat_q   <= 32'd0;
         i_w_enb_q   <= 1'b0;
         d_w_addr_q  <= 10'd0;
         d_w_dat_q   <= 32'd0;
         d_w_enb_q   <= 1'b0;
         init_done_q <= 1'b0;
         pc_stall_q  <= 1'b1;
         i_r_enb_q   <= 1'b0;
         load_err_q  <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         csum_q      <= 32'd0;
`endif
      end else begin
         state_q   <= state_d;
         s_ready_q <= (state_d == HDR) || (state_d == LOAD_D) ||
                      (state_d == LOAD_I) || (state_d == CHK);
         i_w_enb_q <= 1'b0;
         d_w_enb_q <= 1'b0;
         if (beat_s) begin
            case (state_q)
               HDR: begin
                  nd_q  <= bus.s_data[7:0];
                  ni_q  <= bus.s_data[15:8];
                  cnt_q <= 8'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                  csum_q <= bus.s_data;
`endif
               end
               LOAD_D: begin
                  d_w_enb_q  <= 1'b1;
                  d_w_addr_q <= {cnt_q, 2'b00};
                  d_w_dat_q  <= bus.s_data;
                  // Counter restarts at zero for the instruction section.
                  cnt_q      <= (state_d == LOAD_D) ? cnt_q + 8'd1 : 8'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                  csum_q     <= csum_step(csum_q, bus.s_data);
`endif
               end
               LOAD_I: begin
                  i_w_enb_q  <= 1'b1;
                  i_w_addr_q <= {cnt_q, 2'b00};
                  i_w_dat_q  <= bus.s_data;
                  cnt_q      <= (state_d == LOAD_I) ? cnt_q + 8'd1 : 8'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                  csum_q     <= csum_step(csum_q, bus.s_data);
`endif
               end
               default: begin
                  cnt_q <= cnt_q;
               end
            endcase
         end
         if (state_d == DONE) begin
            init_done_q <= 1'b1;
            pc_stall_q  <= 1'b0;
            i_r_enb_q   <= 1'b1;
         end
         if (state_d == ERR) begin
            load_err_q  <= 1'b1;
            pc_stall_q  <= 1'b1;
            init_done_q <= 1'b0;
         end
      end
   end

   assign bus.s_ready          = s_ready_q;
   assign bus.i_w_addr         = i_w_addr_q;
   assign bus.i_w_dat          = i_w_dat_q;
   assign bus.i_w_enb          = i_w_enb_q;
   assign bus.d_w_addr         = d_w_addr_q;
   assign bus.d_w_dat          = d_w_dat_q;
   assign bus.d_w_enb          = d_w_enb_q;
   assign bus.d_bram_init_done = init_done_q;
   assign bus.pc_stall         = pc_stall_q;
   assign bus.i_r_enb          = i_r_enb_q;
   assign bus.load_err         = load_err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: random payloads and valid gaps, checked
// against a stream-level model of the expected BRAM writes and handoff timing.
module tb_boot_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;

   boot_loader_if bus();

   boot_loader #(.MAGIC(16'hB007)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef BOOT_LOADER_CHECKSUM_EN
   localparam int CS_WORDS = 1;
`else
   localparam int CS_WORDS = 0;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] stim[$];
   logic [41:0] obs_d[$];
   logic [41:0] obs_i[$];
   logic [41:0] exp_d[$];
   logic [41:0] exp_i[$];
   int          hdr_cyc, done_cyc, err_cyc, stall_cyc, last_w_cyc, last_beat_cyc, consumed;
   int          exp_beats;
   bit          exp_err;

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = 32'd0;
   end

   // Model: what the stream should produce, from the header rules alone.
   task automatic model();
      logic [31:0] h;
      logic [31:0] x;
      int nd, ni;
      h = stim[0];
      nd = int'(h[7:0]);
      ni = int'(h[15:8]);
      exp_d.delete();
      exp_i.delete();
      if (h[31:16] != 16'hB007) begin
         exp_err   = 1'b1;
         exp_beats = 1;
      end else begin
         for (int k = 0; k < nd; k++) exp_d.push_back({10'(k * 4), stim[1 + k]});
         for (int k = 0; k < ni; k++) exp_i.push_back({10'(k * 4), stim[1 + nd + k]});
         exp_beats = 1 + nd + ni + CS_WORDS;
         exp_err   = 1'b0;
         if (CS_WORDS == 1) begin
            x = 32'd0;
            for (int k = 0; k < 1 + nd + ni; k++) x = x ^ stim[k];
            exp_err = (stim[1 + nd + ni] != x);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.s_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Drives stim (mode 0: always valid, 1: toggling, 2: random) and records outputs.
   task automatic run_load(input int mode, input int stop_after, input int budget);
      int idx = 0;
      int extra = 0;
      bit v = 1'b0;
      bit r = 1'b0;
      bit alt = 1'b1;
      obs_d.delete();
      obs_i.delete();
      hdr_cyc = -1; done_cyc = -1; err_cyc = -1; stall_cyc = -1;
      last_w_cyc = -1; last_beat_cyc = -1;
      for (int c = 0; c < budget + 4; c++) begin
         @(negedge clk);
         if (v && r) begin
            if (idx == 0) hdr_cyc = c - 1;
            last_beat_cyc = c - 1;
            idx++;
         end
         if (bus.d_w_enb) begin obs_d.push_back({bus.d_w_addr, bus.d_w_dat}); last_w_cyc = c; end
         if (bus.i_w_enb) begin obs_i.push_back({bus.i_w_addr, bus.i_w_dat}); last_w_cyc = c; end
         if (bus.d_bram_init_done && done_cyc < 0) done_cyc = c;
         if (!bus.pc_stall && stall_cyc < 0) stall_cyc = c;
         if (bus.load_err && err_cyc < 0) err_cyc = c;
         if (idx >= stop_after) extra++;
         if (extra > 3) break;
         case (mode)
            0: v = 1'b1;
            1: begin v = alt; alt = !alt; end
            default: v = 1'($urandom_range(0, 1));
         endcase
         // After a full stream keep offering junk: a terminal loader must refuse it.
         if (idx >= stop_after) v = (stop_after == stim.size());
         bus.s_valid = v;
         bus.s_data  = (idx < stim.size()) ? stim[idx] : $urandom;
         r = bus.s_ready;
      end
      consumed = idx;
      bus.s_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = $urandom;
      repeat (2) @(negedge clk);
      n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
      n_checks++; if ({bus.d_w_enb, bus.i_w_enb} !== 2'b00) begin n_fail++; $display("FAIL rst_enb: got %b want 00", {bus.d_w_enb, bus.i_w_enb}); end
      n_checks++; if ({bus.d_w_addr, bus.i_w_addr} !== 20'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", {bus.d_w_addr, bus.i_w_addr}); end
      n_checks++; if ({bus.d_w_dat, bus.i_w_dat} !== 64'd0) begin n_fail++; $display("FAIL rst_dat: got %h want 0", {bus.d_w_dat, bus.i_w_dat}); end
      n_checks++; if ({bus.d_bram_init_done, bus.pc_stall, bus.i_r_enb, bus.load_err} !== 4'b0100) begin
         n_fail++; $display("FAIL rst_ctrl: got %b want 0100", {bus.d_bram_init_done, bus.pc_stall, bus.i_r_enb, bus.load_err}); end
      bus.s_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready: got %b want 0", bus.s_ready); end
      @(negedge clk);
      n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL ready_rise: got %b want 1", bus.s_ready); end
   endtask

   task automatic test_load_scenario(input string name, input logic [31:0] hdr, input int mode,
                                     input bit bad_cs, input bit no_reset);
      int nd, ni;
      logic [31:0] x;
      if (!no_reset) do_reset();
      stim.delete();
      stim.push_back(hdr);
      nd = int'(hdr[7:0]);
      ni = int'(hdr[15:8]);
      for (int k = 0; k < nd + ni; k++) stim.push_back($urandom);
      if (CS_WORDS == 1) begin
         x = 32'd0;
         foreach (stim[k]) x = x ^ stim[k];
         stim.push_back(bad_cs ? (x ^ 32'd1) : x);
      end
      model();
      run_load(mode, stim.size(), 4 * stim.size() + 16);

      n_checks++; if (consumed != exp_beats) begin n_fail++; $display("FAIL %s beats: got %0d want %0d", name, consumed, exp_beats); end
      n_checks++; if (obs_d.size() != exp_d.size()) begin n_fail++; $display("FAIL %s d_count: got %0d want %0d", name, obs_d.size(), exp_d.size()); end
      for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
         n_checks++; if (obs_d[k] !== exp_d[k]) begin n_fail++; $display("FAIL %s d_write[%0d]: got %h want %h", name, k, obs_d[k], exp_d[k]); end
      end
      n_checks++; if (obs_i.size() != exp_i.size()) begin n_fail++; $display("FAIL %s i_count: got %0d want %0d", name, obs_i.size(), exp_i.size()); end
      for (int k = 0; k < obs_i.size() && k < exp_i.size(); k++) begin
         n_checks++; if (obs_i[k] !== exp_i[k]) begin n_fail++; $display("FAIL %s i_write[%0d]: got %h want %h", name, k, obs_i[k], exp_i[k]); end
      end
      if (exp_err) begin
         n_checks++; if (err_cyc - last_beat_cyc != 1) begin n_fail++; $display("FAIL %s err_latency: got %0d want 1", name, err_cyc - last_beat_cyc); end
         n_checks++; if ({bus.load_err, bus.pc_stall, bus.d_bram_init_done, bus.s_ready} !== 4'b1100) begin
            n_fail++; $display("FAIL %s err_outputs: got %b want 1100", name, {bus.load_err, bus.pc_stall, bus.d_bram_init_done, bus.s_ready}); end
         n_checks++; if (stall_cyc != -1) begin n_fail++; $display("FAIL %s err_stall_fell: got cycle %0d want never", name, stall_cyc); end
      end else begin
         n_checks++; if (done_cyc - last_beat_cyc != 1) begin n_fail++; $display("FAIL %s done_latency: got %0d want 1", name, done_cyc - last_beat_cyc); end
         if (mode == 0) begin
            n_checks++; if (done_cyc - hdr_cyc != exp_beats) begin n_fail++; $display("FAIL %s hdr_to_done: got %0d want %0d", name, done_cyc - hdr_cyc, exp_beats); end
         end
         n_checks++; if (stall_cyc != done_cyc) begin n_fail++; $display("FAIL %s stall_fall: got %0d want %0d", name, stall_cyc, done_cyc); end
         n_checks++; if ({bus.i_r_enb, bus.load_err, bus.s_ready} !== 3'b100) begin
            n_fail++; $display("FAIL %s done_outputs: got %b want 100", name, {bus.i_r_enb, bus.load_err, bus.s_ready}); end
         if (nd + ni > 0 && CS_WORDS == 0) begin
            n_checks++; if (last_w_cyc != done_cyc) begin n_fail++; $display("FAIL %s last_write_cycle: got %0d want %0d", name, last_w_cyc, done_cyc); end
         end
         if (nd > 0) begin
            n_checks++; if (bus.d_w_addr !== 10'((nd - 1) * 4)) begin n_fail++; $display("FAIL %s d_addr_hold: got %h want %h", name, bus.d_w_addr, 10'((nd - 1) * 4)); end
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      stim.delete();
      stim.push_back(32'hB0070004);
      for (int k = 0; k < 4; k++) stim.push_back($urandom);
      run_load(0, 3, 20);
      n_checks++; if (obs_d.size() != 2) begin n_fail++; $display("FAIL mid_partial_writes: got %0d want 2", obs_d.size()); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({bus.s_ready, bus.d_w_enb, bus.d_bram_init_done, bus.pc_stall, bus.load_err} !== 5'b00010) begin
         n_fail++; $display("FAIL mid_rst_ctrl: got %b want 00010", {bus.s_ready, bus.d_w_enb, bus.d_bram_init_done, bus.pc_stall, bus.load_err}); end
      n_checks++; if ({bus.d_w_addr, bus.d_w_dat} !== 42'd0) begin n_fail++; $display("FAIL mid_rst_data: got %h want 0", {bus.d_w_addr, bus.d_w_dat}); end
      @(negedge clk);
      rst = 1'b0;
      test_load_scenario("fresh_after_mid_rst", 32'hB0070004, 0, 1'b0, 1'b1);
   endtask

   task automatic test_random_loads();
      logic [7:0] nd, ni;
      logic [15:0] tag;
      for (int r = 0; r < 6; r++) begin
         nd = 8'($urandom_range(0, 6));
         ni = 8'($urandom_range(0, 6));
         test_load_scenario("random", {16'hB007, ni, nd}, 2, 1'b0, 1'b0);
      end
      tag = 16'($urandom);
      if (tag == 16'hB007) tag = tag ^ 16'h0001;
      test_load_scenario("random_bad_tag", {tag, 8'h02, 8'h01}, 2, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_scenario("spec_load", 32'hB0070E04, 0, 1'b0, 1'b0);
      test_load_scenario("bad_tag", 32'hDEAD0101, 0, 1'b0, 1'b0);
      test_load_scenario("zero_count", 32'hB0070000, 0, 1'b0, 1'b0);
      test_load_scenario("valid_gaps", 32'hB0070102, 1, 1'b0, 1'b0);
      test_mid_reset();
      test_random_loads();
      if (CS_WORDS == 1) begin
         test_load_scenario("checksum_bad", 32'hB0070203, 0, 1'b1, 1'b0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
